// File: rtl/spi_slave_tx_sequencer.sv
// spi_slave_tx_sequencer
//   Mode-0 SPI slave frame controller. One transmit word is latched per
//   chip-select frame. The word goes to an external 16:1 bit mux, and the mux
//   select is stepped MSB-first on SCLK falling edges to produce MISO. MOSI is
//   shifted in on SCLK rising edges, and each completed word is handed to the
//   core.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   sclk, cs_n, mosi SPI pins (asynchronous to clk)
//   miso             registered slave-out bit
//   mux_word/mux_sel frame word and bit select sent to the external mux
//   mux_out          selected bit returned from the mux
//   tx_data/valid/ready  core transmit handshake into the holding register
//   rx_data/rx_valid last received word and its one-clk update pulse
//   underrun, abort  one-clk status pulses
//   busy             frame in progress (ACTIVE or DONE)
module spi_slave_tx_sequencer #(
  parameter int WORD_BITS   = 16,
  parameter int SEL_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [WORD_BITS-1:0] mux_word,
  output logic [SEL_W-1:0]     mux_sel,
  input  logic                 mux_out,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 underrun,
  output logic                 abort,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(WORD_BITS + 1);
  localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [WORD_BITS-1:0]   hold_q;
  logic                   hold_full;
  logic                   tx_hs;
  logic                   frame_start;
  logic [WORD_BITS-1:0]   rx_shift;
  logic [CNT_W-1:0]       bit_cnt;

  // Input synchronizers and one-clk delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync[0] <= sclk;
      cs_sync[0]   <= cs_n;
      mosi_sync[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign tx_hs       = tx_valid & ~hold_full;
  assign frame_start = (state == IDLE) && cs_fall;

  // Holding register. A frame start consumes the contents present before
  // this clk, so a same-clk handshake lands in the register for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (tx_hs) begin
      hold_q    <= tx_data;
      hold_full <= 1'b1;
    end else if (frame_start) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A cs_n rise wins over an sclk edge in the same clk.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (cs_fall) state_nxt = ACTIVE;
      ACTIVE: begin
        if (cs_rise)                               state_nxt = IDLE;
        else if (sclk_rise && bit_cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    tx_ready = ~hold_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso     <= 1'b0;
      mux_word <= '0;
      mux_sel  <= SEL_TOP;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      miso     <= (state != IDLE) ? mux_out : 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            mux_word <= hold_full ? hold_q : '0;
            underrun <= ~hold_full;
            mux_sel  <= SEL_TOP;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            abort    <= 1'b1;
            rx_shift <= '0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[WORD_BITS-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_LAST) begin
              rx_data  <= {rx_shift[WORD_BITS-2:0], mosi_s};
              rx_valid <= 1'b1;
            end
          end else if (sclk_fall) begin
            mux_sel <= (mux_sel == '0) ? SEL_TOP : mux_sel - SEL_W'(1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
